// File: rtl/risc_mem_stage.sv
// Memory stage: takes execute results, runs load/store accesses over a req/ack
// data-memory handshake, and registers MD/RW/DA/FUNC/DATA/NxorV for write-back.
// Optional access watchdog and sticky MEM_ERR output: define RISC_MEM_TIMEOUT_EN.
module risc_mem_stage
`ifdef RISC_MEM_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 32'd16)
`endif
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        EX_VALID,
  input  logic        FLUSH,
  input  logic [1:0]  MD_0,
  input  logic        RW_0,
  input  logic [4:0]  DA_0,
  input  logic        MW_0,
  input  logic [31:0] FUNC_IN,
  input  logic [31:0] STORE_DATA,
  input  logic        N_0,
  input  logic        V_0,
  output logic        STALL,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic [1:0]  MD_1,
  output logic        RW_1,
  output logic [4:0]  DA_1,
  output logic [31:0] FUNC_OUT,
  output logic [31:0] DATA_OUT,
`ifdef RISC_MEM_TIMEOUT_EN
  output logic        MEM_ERR,
`endif
  output logic        NxorV
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

`ifdef RISC_MEM_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 32'd1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 32'd1);
`endif

  logic [0:0]  state_q, state_d;

  // Instruction parked while its access is outstanding.
  logic [1:0]  hold_md_q, hold_md_d;
  logic        hold_rw_q, hold_rw_d;
  logic [4:0]  hold_da_q, hold_da_d;
  logic [31:0] hold_func_q, hold_func_d;
  logic        hold_nv_q, hold_nv_d;
  logic        hold_mw_q, hold_mw_d;

  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]  md1_q, md1_d;
  logic        rw1_q, rw1_d;
  logic [4:0]  da1_q, da1_d;
  logic [31:0] func_out_q, func_out_d;
  logic [31:0] data_out_q, data_out_d;
  logic        nxorv_q, nxorv_d;

`ifdef RISC_MEM_TIMEOUT_EN
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            mem_err_q, mem_err_d;
`endif

  logic accept_s;
  logic mem_op_s;

  assign accept_s = (state_q == ST_IDLE) && EX_VALID && !FLUSH;
  assign mem_op_s = (MD_0 == 2'd1) || MW_0;

  // Next-state, memory-port and write-back register computation.
  always_comb begin
    state_d     = state_q;
    hold_md_d   = hold_md_q;
    hold_rw_d   = hold_rw_q;
    hold_da_d   = hold_da_q;
    hold_func_d = hold_func_q;
    hold_nv_d   = hold_nv_q;
    hold_mw_d   = hold_mw_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    md1_d       = md1_q;
    rw1_d       = rw1_q;
    da1_d       = da1_q;
    func_out_d  = func_out_q;
    data_out_d  = data_out_q;
    nxorv_d     = nxorv_q;
`ifdef RISC_MEM_TIMEOUT_EN
    wdog_d      = wdog_q;
    mem_err_d   = mem_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (mem_op_s) begin
            hold_md_d   = MD_0;
            hold_rw_d   = RW_0;
            hold_da_d   = DA_0;
            hold_func_d = FUNC_IN;
            hold_nv_d   = N_0 ^ V_0;
            hold_mw_d   = MW_0;
            mem_addr_d  = FUNC_IN;
            mem_wdata_d = STORE_DATA;
            mem_we_d    = MW_0;
            md1_d       = 2'd0;
            rw1_d       = 1'b0;
            da1_d       = 5'd0;
            func_out_d  = 32'd0;
            nxorv_d     = 1'b0;
            state_d     = ST_ACCESS;
`ifdef RISC_MEM_TIMEOUT_EN
            wdog_d      = '0;
`endif
          end else begin
            md1_d      = MD_0;
            rw1_d      = RW_0;
            da1_d      = DA_0;
            func_out_d = FUNC_IN;
            nxorv_d    = N_0 ^ V_0;
            state_d    = ST_IDLE;
          end
        end else begin
          md1_d      = 2'd0;
          rw1_d      = 1'b0;
          da1_d      = 5'd0;
          func_out_d = 32'd0;
          nxorv_d    = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        // WB registers already hold the bubble written on the accept edge.
        if (MEM_ACK) begin
          md1_d      = hold_md_q;
          rw1_d      = hold_rw_q;
          da1_d      = hold_da_q;
          func_out_d = hold_func_q;
          nxorv_d    = hold_nv_q;
          data_out_d = hold_mw_q ? 32'd0 : MEM_RDATA;
          state_d    = ST_IDLE;
        end else begin
`ifdef RISC_MEM_TIMEOUT_EN
          if (wdog_q == WD_LAST) begin
            mem_err_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            wdog_d  = wdog_q + {{(WD_W-1){1'b0}}, 1'b1};
            state_d = ST_ACCESS;
          end
`else
          state_d = ST_ACCESS;
`endif
        end
      end

      default: begin
        md1_d      = 2'd0;
        rw1_d      = 1'b0;
        da1_d      = 5'd0;
        func_out_d = 32'd0;
        nxorv_d    = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset abandons any access in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      hold_md_q   <= 2'd0;
      hold_rw_q   <= 1'b0;
      hold_da_q   <= 5'd0;
      hold_func_q <= 32'd0;
      hold_nv_q   <= 1'b0;
      hold_mw_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      md1_q       <= 2'd0;
      rw1_q       <= 1'b0;
      da1_q       <= 5'd0;
      func_out_q  <= 32'd0;
      data_out_q  <= 32'd0;
      nxorv_q     <= 1'b0;
`ifdef RISC_MEM_TIMEOUT_EN
      wdog_q      <= '0;
      mem_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_md_q   <= hold_md_d;
      hold_rw_q   <= hold_rw_d;
      hold_da_q   <= hold_da_d;
      hold_func_q <= hold_func_d;
      hold_nv_q   <= hold_nv_d;
      hold_mw_q   <= hold_mw_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      md1_q       <= md1_d;
      rw1_q       <= rw1_d;
      da1_q       <= da1_d;
      func_out_q  <= func_out_d;
      data_out_q  <= data_out_d;
      nxorv_q     <= nxorv_d;
`ifdef RISC_MEM_TIMEOUT_EN
      wdog_q      <= wdog_d;
      mem_err_q   <= mem_err_d;
`endif
    end
  end

  // REQ and STALL are a direct decode of the state flop, so reset drops them at once.
  assign STALL     = (state_q == ST_ACCESS);
  assign MEM_REQ   = (state_q == ST_ACCESS);
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign MD_1      = md1_q;
  assign RW_1      = rw1_q;
  assign DA_1      = da1_q;
  assign FUNC_OUT  = func_out_q;
  assign DATA_OUT  = data_out_q;
  assign NxorV     = nxorv_q;
`ifdef RISC_MEM_TIMEOUT_EN
  assign MEM_ERR   = mem_err_q;
`endif

endmodule

// File: tb/tb_risc_mem_stage.sv
// Directed self-checking bench for risc_mem_stage; the watchdog scenario runs
// only when RISC_MEM_TIMEOUT_EN is defined (instantiated with TIMEOUT_CYCLES=4).
module tb_risc_mem_stage;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        EX_VALID, FLUSH, RW_0, MW_0, N_0, V_0, MEM_ACK;
  logic [1:0]  MD_0;
  logic [4:0]  DA_0;
  logic [31:0] FUNC_IN, STORE_DATA, MEM_RDATA;
  logic        STALL, MEM_REQ, MEM_WE, RW_1, NxorV;
  logic [31:0] MEM_ADDR, MEM_WDATA, FUNC_OUT, DATA_OUT;
  logic [1:0]  MD_1;
  logic [4:0]  DA_1;
`ifdef RISC_MEM_TIMEOUT_EN
  logic        MEM_ERR;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 CLK = ~CLK;

`ifdef RISC_MEM_TIMEOUT_EN
  risc_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
`else
  risc_mem_stage dut (
`endif
    .CLK(CLK), .RESET_N(RESET_N), .EX_VALID(EX_VALID), .FLUSH(FLUSH),
    .MD_0(MD_0), .RW_0(RW_0), .DA_0(DA_0), .MW_0(MW_0),
    .FUNC_IN(FUNC_IN), .STORE_DATA(STORE_DATA), .N_0(N_0), .V_0(V_0),
    .STALL(STALL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
    .MD_1(MD_1), .RW_1(RW_1), .DA_1(DA_1),
    .FUNC_OUT(FUNC_OUT), .DATA_OUT(DATA_OUT),
`ifdef RISC_MEM_TIMEOUT_EN
    .MEM_ERR(MEM_ERR),
`endif
    .NxorV(NxorV)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input logic [1:0] md, input logic rw, input logic [4:0] da,
                        input logic mw, input logic [31:0] func, input logic [31:0] sd,
                        input logic n, input logic v);
    EX_VALID = 1'b1; MD_0 = md; RW_0 = rw; DA_0 = da; MW_0 = mw;
    FUNC_IN = func; STORE_DATA = sd; N_0 = n; V_0 = v;
  endtask

  task automatic test_reset();
    #1;
    vecs++; if (STALL !== 1'b0) begin errs++; $display("FAIL rst_stall got %0b want 0", STALL); end
    vecs++; if (MEM_REQ !== 1'b0) begin errs++; $display("FAIL rst_req got %0b want 0", MEM_REQ); end
    vecs++; if ({MEM_WE, MEM_ADDR, MEM_WDATA} !== 65'd0) begin errs++; $display("FAIL rst_mem got %0h want 0", {MEM_WE, MEM_ADDR, MEM_WDATA}); end
    vecs++; if ({MD_1, RW_1, DA_1, NxorV} !== 9'd0) begin errs++; $display("FAIL rst_wb got %0h want 0", {MD_1, RW_1, DA_1, NxorV}); end
    vecs++; if ({FUNC_OUT, DATA_OUT} !== 64'd0) begin errs++; $display("FAIL rst_data got %0h want 0", {FUNC_OUT, DATA_OUT}); end
`ifdef RISC_MEM_TIMEOUT_EN
    vecs++; if (MEM_ERR !== 1'b0) begin errs++; $display("FAIL rst_err got %0b want 0", MEM_ERR); end
`endif
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic test_alu();
    set_op(2'd0, 1'b1, 5'd5, 1'b0, 32'h1234, 32'h0, 1'b1, 1'b0);
    vecs++; if (STALL !== 1'b0) begin errs++; $display("FAIL alu_stall_pre got %0b want 0", STALL); end
    tick();
    EX_VALID = 1'b0;
    vecs++; if ({MD_1, RW_1, DA_1} !== {2'd0, 1'b1, 5'd5}) begin errs++; $display("FAIL alu_ctl got %0h want %0h", {MD_1, RW_1, DA_1}, {2'd0, 1'b1, 5'd5}); end
    vecs++; if (FUNC_OUT !== 32'h1234) begin errs++; $display("FAIL alu_func got %0h want 1234", FUNC_OUT); end
    vecs++; if (NxorV !== 1'b1) begin errs++; $display("FAIL alu_nxv got %0b want 1", NxorV); end
    vecs++; if (STALL !== 1'b0 || MEM_REQ !== 1'b0) begin errs++; $display("FAIL alu_stall got %0b%0b want 00", STALL, MEM_REQ); end
    tick();
    vecs++; if (RW_1 !== 1'b0 || FUNC_OUT !== 32'd0) begin errs++; $display("FAIL idle_bubble got %0b/%0h want 0/0", RW_1, FUNC_OUT); end
  endtask

  task automatic test_load();
    set_op(2'd1, 1'b1, 5'd3, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
    tick();
    vecs++; if (RW_1 !== 1'b0 || MD_1 !== 2'd0) begin errs++; $display("FAIL ld_bubble got %0b/%0d want 0/0", RW_1, MD_1); end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if ({MEM_REQ, STALL, MEM_WE} !== 3'b110 || MEM_ADDR !== 32'h100) begin
        errs++; $display("FAIL ld_access%0d got req/stall/we=%b addr=%0h want 110/100", i, {MEM_REQ, STALL, MEM_WE}, MEM_ADDR);
      end
      if (i == 3) begin MEM_ACK = 1'b1; MEM_RDATA = 32'hCAFEF00D; end
      tick();
      MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
    end
    vecs++; if ({MD_1, RW_1, DA_1} !== {2'd1, 1'b1, 5'd3}) begin errs++; $display("FAIL ld_ctl got %0h want %0h", {MD_1, RW_1, DA_1}, {2'd1, 1'b1, 5'd3}); end
    vecs++; if (DATA_OUT !== 32'hCAFEF00D) begin errs++; $display("FAIL ld_data got %0h want cafef00d", DATA_OUT); end
    vecs++; if (FUNC_OUT !== 32'h100) begin errs++; $display("FAIL ld_func got %0h want 100", FUNC_OUT); end
    vecs++; if (MEM_REQ !== 1'b0 || STALL !== 1'b0) begin errs++; $display("FAIL ld_done got %0b%0b want 00", MEM_REQ, STALL); end
    set_op(2'd0, 1'b1, 5'd7, 1'b0, 32'h55, 32'h0, 1'b0, 1'b1);
    tick();
    EX_VALID = 1'b0;
    vecs++; if ({DA_1, FUNC_OUT, NxorV} !== {5'd7, 32'h55, 1'b1}) begin errs++; $display("FAIL ld_next got %0h want %0h", {DA_1, FUNC_OUT, NxorV}, {5'd7, 32'h55, 1'b1}); end
    vecs++; if (DATA_OUT !== 32'hCAFEF00D) begin errs++; $display("FAIL ld_hold got %0h want cafef00d", DATA_OUT); end
  endtask

  task automatic test_store(input logic [1:0] md, input logic [31:0] addr, input logic [31:0] wd);
    set_op(md, 1'b0, 5'd9, 1'b1, addr, wd, 1'b0, 1'b0);
    tick();
    vecs++; if ({RW_1, FUNC_OUT} !== 33'd0) begin errs++; $display("FAIL st_bubble got %0h want 0", {RW_1, FUNC_OUT}); end
    vecs++; if ({MEM_REQ, MEM_WE} !== 2'b11 || MEM_ADDR !== addr || MEM_WDATA !== wd) begin
      errs++; $display("FAIL st_port got req/we=%b addr=%0h wd=%0h want 11/%0h/%0h", {MEM_REQ, MEM_WE}, MEM_ADDR, MEM_WDATA, addr, wd);
    end
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0; EX_VALID = 1'b0;
    vecs++; if ({MD_1, RW_1, DA_1} !== {md, 1'b0, 5'd9} || FUNC_OUT !== addr) begin errs++; $display("FAIL st_wb got %0h/%0h want %0h/%0h", {MD_1, RW_1, DA_1}, FUNC_OUT, {md, 1'b0, 5'd9}, addr); end
    vecs++; if (DATA_OUT !== 32'd0) begin errs++; $display("FAIL st_data got %0h want 0", DATA_OUT); end
    vecs++; if (MEM_REQ !== 1'b0) begin errs++; $display("FAIL st_done got %0b want 0", MEM_REQ); end
  endtask

  task automatic test_flush();
    set_op(2'd1, 1'b1, 5'd4, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0);
    FLUSH = 1'b1;
    tick();
    vecs++; if (MEM_REQ !== 1'b0 || RW_1 !== 1'b0 || STALL !== 1'b0) begin errs++; $display("FAIL fl_idle got %0b%0b%0b want 000", MEM_REQ, RW_1, STALL); end
    FLUSH = 1'b0;
    tick();
    vecs++; if (MEM_REQ !== 1'b1) begin errs++; $display("FAIL fl_accept got %0b want 1", MEM_REQ); end
    FLUSH = 1'b1;
    tick();
    vecs++; if (MEM_REQ !== 1'b1 || MEM_ADDR !== 32'h300) begin errs++; $display("FAIL fl_access got %0b/%0h want 1/300", MEM_REQ, MEM_ADDR); end
    FLUSH = 1'b0; MEM_ACK = 1'b1; MEM_RDATA = 32'h600DBEEF;
    tick();
    MEM_ACK = 1'b0; EX_VALID = 1'b0;
    vecs++; if (DATA_OUT !== 32'h600DBEEF || RW_1 !== 1'b1 || DA_1 !== 5'd4) begin errs++; $display("FAIL fl_done got %0h/%0b/%0d want 600dbeef/1/4", DATA_OUT, RW_1, DA_1); end
    MEM_ACK = 1'b1; MEM_RDATA = 32'h12345678;
    tick();
    MEM_ACK = 1'b0;
    vecs++; if (DATA_OUT !== 32'h600DBEEF || MEM_REQ !== 1'b0 || RW_1 !== 1'b0) begin errs++; $display("FAIL stray_ack got %0h/%0b/%0b want 600dbeef/0/0", DATA_OUT, MEM_REQ, RW_1); end
  endtask

  task automatic test_md3();
    set_op(2'd3, 1'b1, 5'd31, 1'b0, 32'hFFFF0000, 32'h0, 1'b1, 1'b1);
    tick();
    EX_VALID = 1'b0;
    vecs++; if ({MD_1, DA_1, NxorV, STALL} !== {2'd3, 5'd31, 1'b0, 1'b0} || FUNC_OUT !== 32'hFFFF0000) begin
      errs++; $display("FAIL md3 got %0h/%0h want %0h/ffff0000", {MD_1, DA_1, NxorV, STALL}, FUNC_OUT, {2'd3, 5'd31, 1'b0, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    set_op(2'd1, 1'b1, 5'd2, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    vecs++; if (MEM_REQ !== 1'b1) begin errs++; $display("FAIL rm_pre got %0b want 1", MEM_REQ); end
    #2 RESET_N = 1'b0;
    #1;
    vecs++; if (MEM_REQ !== 1'b0 || STALL !== 1'b0 || MEM_WE !== 1'b0) begin errs++; $display("FAIL rm_async got %0b%0b%0b want 000", MEM_REQ, STALL, MEM_WE); end
    vecs++; if ({MEM_ADDR, DATA_OUT, FUNC_OUT} !== 96'd0) begin errs++; $display("FAIL rm_zero got %0h want 0", {MEM_ADDR, DATA_OUT, FUNC_OUT}); end
    tick();
    RESET_N = 1'b1; EX_VALID = 1'b0; MEM_ACK = 1'b1; MEM_RDATA = 32'hDEADBEEF;
    tick();
    MEM_ACK = 1'b0;
    vecs++; if (MEM_REQ !== 1'b0 || RW_1 !== 1'b0 || DATA_OUT !== 32'd0) begin errs++; $display("FAIL rm_stray got %0b/%0b/%0h want 0/0/0", MEM_REQ, RW_1, DATA_OUT); end
  endtask

`ifdef RISC_MEM_TIMEOUT_EN
  task automatic test_timeout();
    set_op(2'd1, 1'b1, 5'd6, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      vecs++; if (MEM_REQ !== 1'b1 || MEM_ERR !== 1'b0) begin errs++; $display("FAIL to_wait%0d got req/err=%0b%0b want 10", i, MEM_REQ, MEM_ERR); end
      tick();
    end
    vecs++; if (MEM_REQ !== 1'b0 || STALL !== 1'b0 || MEM_ERR !== 1'b1 || RW_1 !== 1'b0) begin
      errs++; $display("FAIL to_abort got req/stall/err/rw=%0b%0b%0b%0b want 0010", MEM_REQ, STALL, MEM_ERR, RW_1);
    end
    set_op(2'd0, 1'b1, 5'd8, 1'b0, 32'h77, 32'h0, 1'b0, 1'b0);
    tick();
    EX_VALID = 1'b0;
    vecs++; if ({RW_1, DA_1} !== {1'b1, 5'd8} || FUNC_OUT !== 32'h77 || MEM_ERR !== 1'b1) begin
      errs++; $display("FAIL to_after got %0h/%0h/%0b want %0h/77/1", {RW_1, DA_1}, FUNC_OUT, MEM_ERR, {1'b1, 5'd8});
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "bench time limit");
  end

  initial begin
    RESET_N = 1'b0; EX_VALID = 1'b0; FLUSH = 1'b0; MD_0 = 2'd0; RW_0 = 1'b0;
    DA_0 = 5'd0; MW_0 = 1'b0; FUNC_IN = 32'd0; STORE_DATA = 32'd0;
    N_0 = 1'b0; V_0 = 1'b0; MEM_ACK = 1'b0; MEM_RDATA = 32'd0;
    test_reset();
    test_alu();
    test_load();
    test_store(2'd0, 32'h200, 32'hA5A5A5A5);
    test_store(2'd1, 32'h204, 32'h0F0F0F0F);
    test_flush();
    test_md3();
    test_reset_mid();
`ifdef RISC_MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
